fifo_rd_stream: RTL and testbench

//  Read-side master for sync_fifo. It drains the FIFO through its rd_en/rd_data/empty port and presents the data as a

---
 rtl/fifo_rd_stream_pkg.sv | 11 +
 rtl/fifo_rd_obuf.sv | 56 +++++
 rtl/fifo_rd_stream.sv | 66 ++++++
 tb/tb_fifo_rd_stream.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and helpers for the sync_fifo read-side stream master.
package fifo_rd_stream_pkg;

  localparam int RDATA_COMB = 0;
  localparam int RDATA_REG  = 1;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// Circular output buffer for fifo_rd_stream: push/din in, pop/dout out, with occupancy and valid.
module fifo_rd_obuf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 3,
  localparam int OW        = occ_width(DEPTH),
  localparam int PW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [OW-1:0]         occ,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic                  do_pop;

  // Pointers wrap explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid  = (occ != '0);
  assign do_pop = pop && valid;
  assign dout   = valid ? mem[head] : '0;

  // NOTE: the storage array has no reset; dout is gated by valid so stale entries never reach the port.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= din;
  end

  // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push)   tail <= wrap_inc(tail);
      if (do_pop) head <= wrap_inc(head);
      case ({push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a sync_fifo read port into a valid/ready stream. Optional beat counter: FIFO_RD_STREAM_STAT_EN.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RDATA_MODE = RDATA_COMB,
  parameter int OBUF_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_STAT_EN
  ,
  output logic [31:0]           beat_cnt
`endif
);

  localparam int OW = occ_width(OBUF_DEPTH);

  logic [OW-1:0] occ;
  logic          infl;
  logic          push;
  logic [OW:0]   pending;

  // A slot is reserved for every read still in flight, so the buffer can never overflow.
  assign pending    = {1'b0, occ} + {{OW{1'b0}}, infl};
  assign fifo_rd_en = !rst && !fifo_empty && (pending < (OW+1)'(OBUF_DEPTH));

  if (RDATA_MODE == RDATA_REG) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) infl <= 1'b0;
      else     infl <= fifo_rd_en;
    end
    assign push = infl;
  end else begin : g_comb
    assign infl = 1'b0;
    assign push = fifo_rd_en;
  end

  fifo_rd_obuf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (OBUF_DEPTH)
  ) u_obuf (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (fifo_rd_data),
    .pop  (m_ready),
    .dout (m_data),
    .occ  (occ),
    .valid(m_valid)
  );

`ifdef FIFO_RD_STREAM_STAT_EN
  always_ff @(posedge clk) begin
    if (rst)                     beat_cnt <= '0;
    else if (m_valid && m_ready) beat_cnt <= beat_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: two fifo_rd_stream instances (RDATA_MODE 0 and 1, depth 3), each fed by a small sync_fifo model.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_rst;
  logic       wr_en;
  logic       m_ready;
  logic [7:0] wr_data;

  logic [1:0]       rd_en;
  logic [1:0]       empty;
  logic [1:0]       m_valid;
  logic [1:0]       uf;
  logic [1:0][7:0]  rd_data;
  logic [1:0][7:0]  m_data;
  logic [1:0][4:0]  fcnt;
`ifdef FIFO_RD_STREAM_STAT_EN
  logic [1:0][31:0] beat_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] got [2][16];
  int         ngot [2];
  int         nrd  [2];

  logic [0:5] exp_rd [2] = '{6'b111000, 6'b111000};
  logic [0:5] exp_v  [2] = '{6'b011100, 6'b001110};
  logic [7:0] exp_d  [2][6] = '{'{8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00},
                                '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00}};
  logic [7:0] exp4   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [7:0] mem [16];
    logic [3:0] wp;
    logic [3:0] rp;
    logic [4:0] cnt;
    logic [7:0] rdq;
    logic       ufl;
    logic       do_wr;
    logic       do_rd;

    assign do_wr = wr_en && (cnt != 5'd16);
    assign do_rd = rd_en[g] && (cnt != 5'd0);

    always_ff @(posedge clk) begin
      if (fifo_rst) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        rdq <= '0;
        ufl <= 1'b0;
      end else begin
        if (do_wr) begin
          mem[wp] <= wr_data;
          wp      <= wp + 4'd1;
        end
        if (rd_en[g] && cnt == 5'd0) ufl <= 1'b1;
        if (do_rd) begin
          rdq <= mem[rp];
          rp  <= rp + 4'd1;
        end
        cnt <= cnt + 5'(do_wr) - 5'(do_rd);
      end
    end

    assign empty[g]   = (cnt == 5'd0);
    assign rd_data[g] = (g == 0) ? mem[rp] : rdq;
    assign uf[g]      = ufl;
    assign fcnt[g]    = cnt;

    fifo_rd_stream #(
      .DATA_WIDTH(8),
      .RDATA_MODE(g),
      .OBUF_DEPTH(3)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .fifo_empty  (empty[g]),
      .fifo_rd_en  (rd_en[g]),
      .fifo_rd_data(rd_data[g]),
      .m_valid     (m_valid[g]),
      .m_ready     (m_ready),
      .m_data      (m_data[g])
`ifdef FIFO_RD_STREAM_STAT_EN
      ,
      .beat_cnt    (beat_cnt[g])
`endif
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic clear_beats();
    for (int ch = 0; ch < 2; ch++) ngot[ch] = 0;
    for (int ch = 0; ch < 2; ch++)
      for (int i = 0; i < 16; i++) got[ch][i] = 8'h00;
  endtask

  task automatic sample_beats();
    for (int ch = 0; ch < 2; ch++) begin
      if (m_valid[ch] && m_ready) begin
        if (ngot[ch] < 16) got[ch][ngot[ch]] = m_data[ch];
        ngot[ch]++;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    fifo_rst = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    m_ready  = 1'b0;
    clear_beats();
    repeat (2) at_pos();

    // Reset held while the FIFO is loaded with 0x11, 0x22, 0x33.
    fifo_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en   = (i < 3);
      wr_data = 8'(8'h11 * (i + 1));
      at_neg();
      for (int ch = 0; ch < 2; ch++) begin
        check($sformatf("rst ch%0d c%0d m_valid", ch, i), 32'(m_valid[ch]), 32'd0);
        check($sformatf("rst ch%0d c%0d rd_en", ch, i), 32'(rd_en[ch]), 32'd0);
        check($sformatf("rst ch%0d c%0d m_data", ch, i), 32'(m_data[ch]), 32'd0);
`ifdef FIFO_RD_STREAM_STAT_EN
        check($sformatf("rst ch%0d c%0d beat_cnt", ch, i), beat_cnt[ch], 32'd0);
`endif
      end
      at_pos();
    end

    // Release reset with m_ready=1: cycle-exact issue and delivery timing per mode.
    rst     = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      at_neg();
      for (int ch = 0; ch < 2; ch++) begin
        check($sformatf("burst ch%0d c%0d rd_en", ch, c), 32'(rd_en[ch]), 32'(exp_rd[ch][c]));
        check($sformatf("burst ch%0d c%0d m_valid", ch, c), 32'(m_valid[ch]), 32'(exp_v[ch][c]));
        check($sformatf("burst ch%0d c%0d m_data", ch, c), 32'(m_data[ch]), 32'(exp_d[ch][c]));
      end
      at_pos();
    end

    // Backpressure: 5 words loaded, consumer stalled; only 3 reads may issue.
    m_ready = 1'b0;
    for (int ch = 0; ch < 2; ch++) nrd[ch] = 0;
    for (int i = 0; i < 9; i++) begin
      wr_en   = (i < 5);
      wr_data = (i < 5) ? exp4[i] : 8'h00;
      at_neg();
      for (int ch = 0; ch < 2; ch++) begin
        if (rd_en[ch]) nrd[ch]++;
        if (m_valid[ch]) check($sformatf("stall ch%0d c%0d m_data", ch, i), 32'(m_data[ch]), 32'h11);
      end
      at_pos();
    end
    wr_en = 1'b0;
    at_neg();
    for (int ch = 0; ch < 2; ch++) begin
      check($sformatf("stall ch%0d reads", ch), 32'(nrd[ch]), 32'd3);
      check($sformatf("stall ch%0d rd_en", ch), 32'(rd_en[ch]), 32'd0);
      check($sformatf("stall ch%0d m_valid", ch), 32'(m_valid[ch]), 32'd1);
      check($sformatf("stall ch%0d head", ch), 32'(m_data[ch]), 32'h11);
      check($sformatf("stall ch%0d fifo_cnt", ch), 32'(fcnt[ch]), 32'd2);
    end
    at_pos();

    clear_beats();
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      at_neg();
      sample_beats();
      at_pos();
    end
    at_neg();
    for (int ch = 0; ch < 2; ch++) begin
      check($sformatf("drain ch%0d beats", ch), 32'(ngot[ch]), 32'd5);
      for (int i = 0; i < 5; i++)
        check($sformatf("drain ch%0d beat%0d", ch, i), 32'(got[ch][i]), 32'(exp4[i]));
      check($sformatf("drain ch%0d fifo_cnt", ch), 32'(fcnt[ch]), 32'd0);
    end
    at_pos();

    // Empty FIFO with m_ready toggling: no reads, no underflow.
    for (int i = 0; i < 20; i++) begin
      m_ready = i[0];
      at_neg();
      for (int ch = 0; ch < 2; ch++) begin
        check($sformatf("empty ch%0d c%0d rd_en", ch, i), 32'(rd_en[ch]), 32'd0);
        check($sformatf("empty ch%0d c%0d m_valid", ch, i), 32'(m_valid[ch]), 32'd0);
      end
      at_pos();
    end
    at_neg();
    for (int ch = 0; ch < 2; ch++) check($sformatf("empty ch%0d underflow", ch), 32'(uf[ch]), 32'd0);
    at_pos();

    // Reset mid-stream with 2 beats buffered, then a single clean beat.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en   = (i < 2);
      wr_data = (i == 0) ? 8'h77 : 8'h88;
      at_pos();
    end
    wr_en = 1'b0;
    at_neg();
    for (int ch = 0; ch < 2; ch++) begin
      check($sformatf("pre_rst ch%0d m_valid", ch), 32'(m_valid[ch]), 32'd1);
      check($sformatf("pre_rst ch%0d m_data", ch), 32'(m_data[ch]), 32'h77);
    end
    at_pos();
    rst      = 1'b1;
    fifo_rst = 1'b1;
    at_pos();
    rst      = 1'b0;
    fifo_rst = 1'b0;
    at_neg();
    for (int ch = 0; ch < 2; ch++) begin
      check($sformatf("post_rst ch%0d m_valid", ch), 32'(m_valid[ch]), 32'd0);
      check($sformatf("post_rst ch%0d m_data", ch), 32'(m_data[ch]), 32'd0);
    end
    at_pos();

    clear_beats();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en   = (i == 0);
      wr_data = 8'hA5;
      at_neg();
      sample_beats();
      at_pos();
    end
    wr_en = 1'b0;
    at_neg();
    for (int ch = 0; ch < 2; ch++) begin
      check($sformatf("reload ch%0d beats", ch), 32'(ngot[ch]), 32'd1);
      check($sformatf("reload ch%0d beat0", ch), 32'(got[ch][0]), 32'hA5);
    end
    at_pos();

    // 10 beats with random m_ready after a fresh reset.
    rst      = 1'b1;
    fifo_rst = 1'b1;
    at_pos();
    rst      = 1'b0;
    fifo_rst = 1'b0;
    clear_beats();
    for (int i = 0; i < 60; i++) begin
      wr_en   = (i < 10);
      wr_data = 8'(i * 13 + 5);
      m_ready = 1'($urandom_range(0, 1));
      at_neg();
      sample_beats();
      at_pos();
    end
    wr_en   = 1'b0;
    m_ready = 1'b0;
    at_neg();
    for (int ch = 0; ch < 2; ch++) begin
      check($sformatf("rand ch%0d beats", ch), 32'(ngot[ch]), 32'd10);
      for (int i = 0; i < 10; i++)
        check($sformatf("rand ch%0d beat%0d", ch, i), 32'(got[ch][i]), 32'(8'(i * 13 + 5)));
      check($sformatf("rand ch%0d underflow", ch), 32'(uf[ch]), 32'd0);
`ifdef FIFO_RD_STREAM_STAT_EN
      check($sformatf("rand ch%0d beat_cnt", ch), beat_cnt[ch], 32'd10);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
